// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants, types and index helper for the N:1 round-robin mux.
package mux_pkg;

  localparam logic        MODE_FIXED  = 1'b0;
  localparam logic        MODE_RR     = 1'b1;
  localparam int unsigned GRANT_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Explicit wrap so non-power-of-2 channel counts return to 0.
  function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Producer-side and consumer-side handshake bundle of the N:1 mux.
interface mux_nx1_rr_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SELW = $clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_chan;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/mux_nx1_rr_rr_pick.sv
// Rotating priority encoder: first asserted req at or after ptr, wrapping mod N.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned cur;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cur     = 32'(ptr);
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_any && req[cur[SELW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cur[SELW-1:0];
      end
      cur = inc_mod(cur, N);
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input registered mux with fixed-select or round-robin choice.
// Optional per-channel grant counters: define MUX_GRANT_CNT_EN.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SELW-1:0]          sel,
`ifdef MUX_GRANT_CNT_EN
  output logic [N*GRANT_CNT_W-1:0] grant_cnt,
`endif
  mux_nx1_rr_if.slave              bus
);

  out_state_e      state, state_nxt;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic [SELW-1:0] chosen_idx;
  logic            chosen_any;
  logic            load_en;
  logic [N-1:0]    ready;
  logic            xfer;
  logic [W-1:0]    pick_data;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] chan_q;

  rr_pick #(.N(N)) u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Channel choice, per-channel ready and the accepted beat.
  always_comb begin
    chosen_idx = sel;
    chosen_any = 1'b0;
    if (mode == MODE_RR) begin
      chosen_idx = rr_idx;
      chosen_any = rr_any;
    end else begin
      for (int unsigned i = 0; i < N; i++)
        if (sel == SELW'(i)) chosen_any = 1'b1;
    end

    load_en   = (state == ST_EMPTY) || bus.out_ready;
    ready     = '0;
    pick_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ready[i] = load_en && chosen_any && (chosen_idx == SELW'(i)) && !rst;
      if (chosen_idx == SELW'(i)) pick_data = bus.in_data[i*W +: W];
    end
    xfer = |(bus.in_valid & ready);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      chan_q <= '0;
      ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        data_q <= pick_data;
        chan_q <= chosen_idx;
        if (mode == MODE_RR) ptr <= SELW'(inc_mod(32'(chosen_idx), N));
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (load_en) state_nxt = xfer ? ST_FULL : ST_EMPTY;
  end

  // Outputs
  always_comb begin
    bus.out_valid = (state == ST_FULL);
    bus.out_data  = data_q;
    bus.out_chan  = chan_q;
    bus.in_ready  = ready;
  end

`ifdef MUX_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (xfer) begin
      for (int unsigned i = 0; i < N; i++)
        if (chosen_idx == SELW'(i) && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + GRANT_CNT_W'(1);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N; i++)
      grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: an N=4 and an N=3 instance driven in one sequence.
module tb_mux_nx1_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode4, mode3;
  logic [1:0] sel4, sel3;
  int         checks = 0;
  int         errors = 0;

`ifdef MUX_GRANT_CNT_EN
  logic [4*16-1:0] gcnt4;
  logic [3*16-1:0] gcnt3;
`endif

  mux_nx1_rr_if #(.N(4), .W(8)) b4 ();
  mux_nx1_rr_if #(.N(3), .W(8)) b3 ();

  mux_nx1_rr #(.N(4), .W(8)) u4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode4),
    .sel       (sel4),
`ifdef MUX_GRANT_CNT_EN
    .grant_cnt (gcnt4),
`endif
    .bus       (b4.slave)
  );

  mux_nx1_rr #(.N(3), .W(8)) u3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
`ifdef MUX_GRANT_CNT_EN
    .grant_cnt (gcnt3),
`endif
    .bus       (b3.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    mode4        = 1'b0;
    sel4         = 2'd2;
    b4.in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
    b4.in_valid  = 4'b1111;
    b4.out_ready = 1'b1;
    mode3        = 1'b0;
    sel3         = 2'd3;
    b3.in_data   = {8'hC3, 8'hB2, 8'hA1};
    b3.in_valid  = 3'b000;
    b3.out_ready = 1'b1;

    // Reset and fixed select
    tick();
    check("rst_valid", 32'(b4.out_valid), 0);
    check("rst_data",  32'(b4.out_data),  0);
    check("rst_chan",  32'(b4.out_chan),  0);
    check("rst_ready", 32'(b4.in_ready),  0);
    tick();
    rst = 1'b0;
    #1;
    check("fix_ready_empty", 32'(b4.in_ready), 32'b0100);
    tick();
    check("fix_valid", 32'(b4.out_valid), 1);
    check("fix_data",  32'(b4.out_data),  32'h30);
    check("fix_chan",  32'(b4.out_chan),  2);
    tick();
    check("fix_steady_data", 32'(b4.out_data), 32'h30);
    check("fix_ready_full",  32'(b4.in_ready), 32'b0100);

    // Backpressure hold: held beat ignores new source data
    b4.out_ready = 1'b0;
    b4.in_data   = {8'h40, 8'h33, 8'h20, 8'h10};
    #1;
    check("bp_ready", 32'(b4.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data",  32'(b4.out_data),  32'h30);
      check("bp_valid", 32'(b4.out_valid), 1);
    end
    b4.in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
    b4.in_valid  = 4'b0000;
    b4.out_ready = 1'b1;
    tick();
    check("bp_drain_valid", 32'(b4.out_valid), 0);

    // Round-robin fairness from ptr=0
    mode4       = 1'b1;
    b4.in_valid = 4'b1111;
    #1;
    check("rr_ready0", 32'(b4.in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_chan", 32'(b4.out_chan), 32'(k % 4));
      check("rr_data", 32'(b4.out_data), 32'((k % 4 + 1) * 16));
    end

    // Skip and wrap, ptr=1
    b4.in_valid = 4'b1001;
    #1;
    check("skip_ready", 32'(b4.in_ready), 32'b1000);
    tick();
    check("skip_chan_a", 32'(b4.out_chan), 3);
    check("skip_data_a", 32'(b4.out_data), 32'h40);
    tick();
    check("skip_chan_b", 32'(b4.out_chan), 0);
    check("skip_data_b", 32'(b4.out_data), 32'h10);
    tick();
    check("skip_chan_c", 32'(b4.out_chan), 3);
    b4.in_valid = 4'b0000;
    #1;
    check("rr_none_ready", 32'(b4.in_ready), 0);
    tick();
    check("rr_empty_valid", 32'(b4.out_valid), 0);

    // Fixed mode offers ready to an idle channel
    mode4 = 1'b0;
    sel4  = 2'd1;
    #1;
    check("fix_idle_ready", 32'(b4.in_ready), 32'b0010);
    tick();
    check("fix_idle_valid", 32'(b4.out_valid), 0);

    // Mid-operation reset discards held beat and ptr
    b4.in_valid = 4'b1111;
    tick();
    check("pre_rst_data", 32'(b4.out_data), 32'h20);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(b4.in_ready), 0);
    tick();
    check("rst_mid_valid", 32'(b4.out_valid), 0);
    check("rst_mid_data",  32'(b4.out_data),  0);
    rst   = 1'b0;
    mode4 = 1'b1;
    #1;
    check("rst_ptr_ready", 32'(b4.in_ready), 32'b0001);
    b4.in_valid = 4'b0000;
    tick();

    // N=3: out-of-range select, then round-robin wrap
    b3.in_valid = 3'b111;
    #1;
    check("oor_ready", 32'(b3.in_ready), 0);
    tick();
    tick();
    check("oor_valid", 32'(b3.out_valid), 0);
    sel3 = 2'd1;
    #1;
    check("n3_fix_ready", 32'(b3.in_ready), 32'b010);
    tick();
    check("n3_fix_data", 32'(b3.out_data), 32'hB2);
    check("n3_fix_chan", 32'(b3.out_chan), 1);
    mode3       = 1'b1;
    b3.in_valid = 3'b101;
    #1;
    check("n3_rr_ready", 32'(b3.in_ready), 32'b001);
    tick();
    check("n3_rr_chan_a", 32'(b3.out_chan), 0);
    tick();
    check("n3_rr_chan_b", 32'(b3.out_chan), 2);
    check("n3_rr_data_b", 32'(b3.out_data), 32'hC3);
    tick();
    check("n3_rr_wrap", 32'(b3.out_chan), 0);
    b3.in_valid = 3'b000;
    tick();
    check("n3_empty", 32'(b3.out_valid), 0);

`ifdef MUX_GRANT_CNT_EN
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    mode4       = 1'b0;
    sel4        = 2'd1;
    b4.in_valid = 4'b0010;
    repeat (5) tick();
    b4.in_valid = 4'b0000;
    #1;
    check("cnt_ch1", 32'(gcnt4[31:16]), 5);
    check("cnt_ch0", 32'(gcnt4[15:0]),  0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst", 32'(gcnt4[31:16]), 0);
    sel4        = 2'd0;
    b4.in_valid = 4'b0001;
    repeat (65540) tick();
    b4.in_valid = 4'b0000;
    #1;
    check("cnt_sat",   32'(gcnt4[15:0]),  32'hFFFF);
    check("cnt_other", 32'(gcnt4[31:16]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-input, W-bit multiplexer with a registered output and valid/ready handshakes on every channel.
- Successor to the plain 2:1 mux. Adds two selection modes: fixed select via the sel port, or round-robin arbitration among valid inputs.
- Used wherever several producers share one downstream consumer. Throughput is 1 beat/cycle, latency is 1 cycle.

Parameters:
- N, 4: number of input channels (>=2).
- W, 8: data width per channel.
- SELW, $clog2(N): local parameter giving the channel-index width (not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational, at most one bit high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_data  out  W  registered data.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.
- out_chan  out  SELW  registered source index of out_data.

Behaviour:
- Reset: out_data=0, out_valid=0, out_chan=0, round-robin pointer ptr=0. Reset mid-operation discards any held beat; no in_ready is asserted while rst=1.
- Output register behaves as a 2-state FSM:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid || out_ready.
- Channel choice (combinational):
  - Fixed mode: chosen = sel. If sel >= N, nothing is chosen.
  - Round-robin mode: chosen = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N. If no input is valid, nothing is chosen.
- in_ready[i] = load_en && (i == chosen) && !rst.
  - In fixed mode, in_ready[sel] may be high while in_valid[sel]=0.
  - In round-robin mode, only a valid channel is offered ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next edge: out_data = channel i data, out_chan = i, out_valid = 1.
- If load_en=1 and no transfer occurs, out_valid becomes 0 (FSM goes to EMPTY). If load_en=0, all outputs hold.
- Simultaneous drain and load (out_valid=1, out_ready=1, new transfer) gives back-to-back beats with no bubble.
- Pointer: on a round-robin-mode transfer from channel i, ptr = (i+1) mod N; wrap handled explicitly for non-power-of-2 N. Fixed-mode transfers leave ptr unchanged.
- Mode or sel changes apply in the same cycle they are presented, to choice logic only. A beat already held is unaffected.
- Upstream may drop in_valid without a handshake; the block places no stability requirement on sources.

Optional Feature:
- Macro MUX_GRANT_CNT_EN.
- Defined: adds output grant_cnt, N*16 bits. Slice i is a 16-bit saturating count of transfers accepted from channel i, saturating at 16'hFFFF and cleared by rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mux_pkg holds:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - GRANT_CNT_W=16.
  - A function giving modulo-N increment of an index.
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_any.
  - Used only in round-robin mode.

Test Plan:
1. Reset and fixed select:
   - Stimulus: rst=1 for 2 cycles, then mode=0, sel=2, N=4, W=8, in_valid=4'b1111, data ch0..3 = 0x10, 0x20, 0x30, 0x40, out_ready=1.
   - Response: outputs 0 during reset. One cycle after release, out_valid=1, out_data=0x30, out_chan=2, then steady 0x30 every cycle; in_ready=4'b0100.
2. Backpressure hold:
   - Stimulus: FULL with 0x30, out_ready=0 for 3 cycles.
   - Response: out_data stays 0x30, in_ready=0; exactly one beat is delivered when out_ready returns to 1.
3. Round-robin fairness:
   - Stimulus: mode=1, all valid, out_ready=1, from ptr=0.
   - Response: out_chan sequence 0,1,2,3,0 with matching data.
4. Round-robin skip and wrap:
   - Stimulus: in_valid=4'b1001, ptr=1.
   - Response: grants ch3 then ch0 then ch3. With in_valid=0, out_valid falls to 0 after the last beat drains.
5. Out-of-range select:
   - Stimulus: N=3 build, mode=0, sel=3, all valid.
   - Response: in_ready=0, out_valid stays 0.
6. Counters with MUX_GRANT_CNT_EN defined:
   - Stimulus: 5 transfers from ch1, then rst.
   - Response: grant_cnt[1] = 5 before reset, 0 after. A counter preloaded by 65540 transfers reads 0xFFFF.
